// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU.
// Owns pc, latches fetched instructions and drives datapath strobes and ALU select.
module cpu_sequencer #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic                         start,
  output logic                         instrReq,
  output logic [PC_WIDTH-1:0]          instrAddr,
  input  logic                         instrValid,
  input  logic [INSTRUCTION_WIDTH-1:0] instrData,
  input  logic                         accumulatorZero,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [1:0]                   aluOp,
  output logic [7:0]                   aluOperand,
  output logic                         accWrite,
  output logic                         reg1Write,
  output logic                         halted,
  output logic [COUNT_WIDTH-1:0]       retiredCount
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;

  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_LOADR = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic [2:0]          state;
  logic [2:0]          state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] jump_target;
  logic [3:0]          opcode;
  logic [1:0]          alu_sel;
  logic                alu_writes_acc;

  assign opcode      = instruction[11:8];
  assign aluOperand  = instruction[7:0];
  assign pc_inc      = pc + PC_WIDTH'(1);
  assign jump_target = PC_WIDTH'(instruction[7:0]);

  // Opcode to ALU select and whether the instruction writes the accumulator.
  always_comb begin
    alu_sel        = 2'd0;
    alu_writes_acc = 1'b0;
    case (opcode)
      OP_LOADI: begin alu_sel = 2'd0; alu_writes_acc = 1'b1; end
      OP_ADD:   begin alu_sel = 2'd1; alu_writes_acc = 1'b1; end
      OP_SUB:   begin alu_sel = 2'd2; alu_writes_acc = 1'b1; end
      OP_LOADR: begin alu_sel = 2'd3; alu_writes_acc = 1'b1; end
      default:  begin alu_sel = 2'd0; alu_writes_acc = 1'b0; end
    endcase
  end

  // Next-state and next-pc selection.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
        else       state_next = S_IDLE;
      end
      S_FETCH: begin
        if (instrValid) state_next = S_DECODE;
        else            state_next = S_FETCH;
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        state_next = S_FETCH;
        case (opcode)
          OP_JUMP: pc_next = jump_target;
          OP_JZ: begin
            if (accumulatorZero) pc_next = jump_target;
            else                 pc_next = pc_inc;
          end
          OP_HALT: begin
            pc_next    = pc;
            state_next = S_HALTED;
          end
          default: pc_next = pc_inc;
        endcase
      end
      S_HALTED: begin
        if (start) begin
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end else begin
          pc_next    = pc;
          state_next = S_HALTED;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sequencer state, pc, latched instruction, ALU select and retire counter.
  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      state        <= S_IDLE;
      pc           <= '0;
      instruction  <= '0;
      aluOp        <= 2'd0;
      retiredCount <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == S_FETCH && instrValid) instruction <= instrData;
      if (state == S_DECODE) aluOp <= alu_sel;
      if (state == S_EXECUTE) retiredCount <= retiredCount + COUNT_WIDTH'(1);
    end
  end

  // Handshake and strobes follow state directly so reset clears them at once.
  assign instrReq  = (state == S_FETCH);
  assign instrAddr = pc;
  assign halted    = (state == S_HALTED);
  assign accWrite  = (state == S_EXECUTE) && alu_writes_acc;
  assign reg1Write = (state == S_EXECUTE) && (opcode == OP_STORE);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed programs plus randomized
// instruction streams checked against an instruction-level CPU model.
module tb_cpu_sequencer;
  localparam int PW = 8;
  localparam int IW = 16;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          isReset, start, instrValid, accumulatorZero;
  logic [IW-1:0] instrData;
  logic          instrReq, accWrite, reg1Write, halted;
  logic [PW-1:0] instrAddr, pc;
  logic [IW-1:0] instruction;
  logic [1:0]    aluOp;
  logic [7:0]    aluOperand;
  logic [CW-1:0] retiredCount;

  cpu_sequencer #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .isReset(isReset), .start(start),
    .instrReq(instrReq), .instrAddr(instrAddr),
    .instrValid(instrValid), .instrData(instrData),
    .accumulatorZero(accumulatorZero), .pc(pc), .instruction(instruction),
    .aluOp(aluOp), .aluOperand(aluOperand), .accWrite(accWrite),
    .reg1Write(reg1Write), .halted(halted), .retiredCount(retiredCount)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  logic [IW-1:0] mem [256];
  // Architectural model: pc, retired count, accumulator, register1, halted.
  int m_pc = 0, m_cnt = 0, m_acc = 0, m_r1 = 0;
  bit m_halt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH through EXECUTE, memory answering after 'delay' cycles.
  task automatic exec_one(input int delay);
    logic [IW-1:0] w;
    int op, opd, exp_alu;
    bit exp_acc, exp_r1;
    for (int d = 0; d <= delay; d++) begin
      chk("fetch_req", 32'(instrReq), 1);
      chk("fetch_addr", 32'(instrAddr), m_pc);
      instrValid = (d == delay);
      instrData  = (d == delay) ? mem[m_pc] : 16'($urandom);
      @(negedge clock);
    end
    w = mem[m_pc];
    op = int'(w[11:8]);
    opd = int'(w[7:0]);
    instrValid = 1'($urandom_range(0, 1));
    instrData  = 16'($urandom);
    start      = 1'($urandom_range(0, 1));
    chk("decode_req", 32'(instrReq), 0);
    chk("decode_strobes", 32'({accWrite, reg1Write}), 0);
    chk("decode_instr", 32'(instruction), 32'(w));
    chk("decode_halted", 32'(halted), 0);
    @(negedge clock);
    start = 1'b0;
    instrValid = 1'($urandom_range(0, 1));
    accumulatorZero = (m_acc == 0);
    exp_acc = (op == 1) || (op == 2) || (op == 3) || (op == 5);
    exp_r1  = (op == 4);
    exp_alu = (op == 1) ? 0 : (op == 2) ? 1 : (op == 3) ? 2 : 3;
    chk("exec_accWrite", 32'(accWrite), 32'(exp_acc));
    chk("exec_reg1Write", 32'(reg1Write), 32'(exp_r1));
    chk("exec_operand", 32'(aluOperand), opd);
    chk("exec_req", 32'(instrReq), 0);
    if (exp_acc) chk("exec_aluOp", 32'(aluOp), exp_alu);
    case (op)
      1: m_acc = opd;
      2: m_acc = (m_acc + opd) % 256;
      3: m_acc = (m_acc - opd + 256) % 256;
      4: m_r1 = m_acc;
      5: m_acc = m_r1;
      default: ;
    endcase
    if (op == 6) m_pc = opd;
    else if (op == 7) m_pc = accumulatorZero ? opd : (m_pc + 1) % 256;
    else if (op == 15) m_halt = 1'b1;
    else m_pc = (m_pc + 1) % 256;
    m_cnt = (m_cnt + 1) % (1 << CW);
    @(negedge clock);
    instrValid = 1'b0;
    chk("post_pc", 32'(pc), m_pc);
    chk("post_count", 32'(retiredCount), m_cnt);
    chk("post_halted", 32'(halted), 32'(m_halt));
    chk("post_req", 32'(instrReq), 32'(!m_halt));
  endtask

  // Called at a negedge in HALTED: idles, then pulses start.
  task automatic restart();
    instrValid = 1'b1;
    @(negedge clock);
    chk("halt_hold", 32'(halted), 1);
    chk("halt_no_req", 32'(instrReq), 0);
    instrValid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    m_pc = (m_pc + 1) % 256;
    m_halt = 1'b0;
  endtask

  initial begin
    isReset = 1'b1; start = 1'b0; instrValid = 1'b0; instrData = '0; accumulatorZero = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_count", 32'(retiredCount), 0);
    chk("rst_outs", 32'({instrReq, accWrite, reg1Write, halted, aluOp}), 0);
    @(negedge clock);
    @(negedge clock);
    isReset = 1'b0;
    instrValid = 1'b1;
    @(negedge clock);
    chk("idle_no_req", 32'(instrReq), 0);
    chk("idle_ignores_valid", 32'(instruction), 0);
    instrValid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;

    // Program 1: LOADI 5, ADD 3, STORE, HALT with zero-wait memory.
    mem[0] = 16'h0105; mem[1] = 16'h0203; mem[2] = 16'h0400; mem[3] = 16'h0F00;
    for (int i = 0; i < 4; i++) exec_one(0);
    chk("p1_pc", 32'(pc), 3);
    chk("p1_count", 32'(retiredCount), 4);
    chk("p1_acc_model", m_acc, 8);

    // Program 2: JZ both ways, JUMP, unknown opcode, pc wrap, HALT at 7; two wait states.
    mem[4] = 16'h0740; mem[5] = 16'h0100; mem[6] = 16'h0740;
    mem[8'h40] = 16'h0500; mem[8'h41] = 16'h0610;
    mem[8'h10] = 16'h0A55; mem[8'h11] = 16'h06FE;
    mem[8'hFE] = 16'h0308; mem[8'hFF] = 16'h0000;
    mem[0] = 16'h0607; mem[7] = 16'h0F00;
    restart();
    chk("restart_addr", 32'(instrAddr), 4);
    while (!m_halt) exec_one(2);
    chk("p2_halt_pc", 32'(pc), 7);

    // Randomized instruction stream with random wait states and restarts.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    restart();
    chk("restart_addr8", 32'(instrAddr), 8);
    for (int n = 0; n < 400; n++) begin
      if (m_halt) restart();
      else exec_one($urandom_range(0, 3));
    end
    if (m_halt) restart();

    // Reset while the sequencer waits in FETCH.
    instrValid = 1'b0;
    @(negedge clock);
    chk("pre_rst_req", 32'(instrReq), 1);
    #2 isReset = 1'b1;
    #1;
    chk("async_rst_req", 32'(instrReq), 0);
    chk("async_rst_pc", 32'(pc), 0);
    chk("async_rst_count", 32'(retiredCount), 0);
    chk("async_rst_instr", 32'(instruction), 0);
    @(negedge clock);
    isReset = 1'b0;
    instrValid = 1'b1;
    instrData = 16'h0123;
    @(negedge clock);
    chk("late_valid_req", 32'(instrReq), 0);
    chk("late_valid_instr", 32'(instruction), 0);
    instrValid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    m_pc = 0; m_cnt = 0; m_halt = 1'b0;
    mem[0] = 16'h0111; mem[1] = 16'h0F00;
    exec_one(1);
    exec_one(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the accumulator CPU datapath (pc, instruction, accumulator, register1, aluResult). It owns the program counter, fetches instructions over a request/valid handshake, and decodes them. It drives one-cycle write strobes and ALU select lines into the accumulator/register1 datapath. It also handles jumps, conditional jumps and halt, and counts retired instructions.

## Interface
Parameters:
- PC_WIDTH, 8, program counter / instruction address width
- INSTRUCTION_WIDTH, 16, fetched word width; opcode = bits [11:8], operand = bits [7:0]
- COUNT_WIDTH, 16, retired-instruction counter width

Ports:
- clock  input  1  single clock; all state updates on rising edge
- isReset  input  1  asynchronous, active-high reset
- start  input  1  leave IDLE or HALTED; ignored in other states
- instrReq  output  1  fetch request
- instrAddr  output  PC_WIDTH  fetch address (= pc)
- instrValid  input  1  fetch data valid; sampled only in FETCH
- instrData  input  INSTRUCTION_WIDTH  fetched instruction
- accumulatorZero  input  1  accumulator == 0, from datapath
- pc  output  PC_WIDTH  program counter
- instruction  output  INSTRUCTION_WIDTH  latched current instruction
- aluOp  output  2  0 pass operand, 1 acc+operand, 2 acc-operand, 3 pass register1
- aluOperand  output  8  operand field of latched instruction
- accWrite  output  1  one-cycle strobe: accumulator <= aluResult
- reg1Write  output  1  one-cycle strobe: register1 <= accumulator
- halted  output  1  high in HALTED
- retiredCount  output  COUNT_WIDTH  instructions completed in EXECUTE

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, HALTED.
- Reset values: state IDLE, pc 0, instruction 0, retiredCount 0; instrReq, accWrite, reg1Write and halted are 0; aluOp 0.
- IDLE: start=1 -> FETCH.
- FETCH:
  - instrReq=1 and instrAddr=pc, held until instrValid=1.
  - On instrValid=1: instruction <= instrData, then -> DECODE.
- DECODE: one cycle; aluOp and aluOperand are set from the latched opcode. No strobes.
- EXECUTE: one cycle. Strobes are combinational from state and opcode. Opcodes:
  - 0 NOP: no strobes.
  - 1 LOADI: aluOp=0, accWrite.
  - 2 ADD: aluOp=1, accWrite.
  - 3 SUB: aluOp=2, accWrite.
  - 4 STORE: reg1Write.
  - 5 LOADR: aluOp=3, accWrite.
  - 6 JUMP: pc <= operand[PC_WIDTH-1:0].
  - 7 JZ: pc <= operand if accumulatorZero, else pc+1.
  - F HALT: pc unchanged; -> HALTED.
  - All other opcodes: NOP.
- pc update: non-jump, non-HALT instructions do pc <= pc+1, wrapping modulo 2^PC_WIDTH (pc=255 -> 0).
- retiredCount increments once per EXECUTE, HALT included, and wraps at 2^COUNT_WIDTH.
- EXECUTE -> FETCH, except after HALT.
- HALTED: halted=1. start=1 -> pc <= pc+1, then -> FETCH.

## Timing
- Minimum 3 cycles per instruction (FETCH with same-cycle instrValid, DECODE, EXECUTE); each cycle of instrValid delay adds one.
- instrReq is combinational from state, so it drops in the cycle after the accepting edge.
- Strobes are high exactly one cycle, in EXECUTE. accumulatorZero is sampled in that cycle, reflecting the previous instruction's result.
- instrValid outside FETCH is ignored. start outside IDLE/HALTED is ignored.
- isReset asserted mid-fetch or mid-EXECUTE: all outputs go to reset values immediately, without waiting for a clock edge. No partial pc or counter update occurs.
- First FETCH after release needs start.

## Test plan
- Reset then start, memory answering same cycle:
  - program LOADI 5, ADD 3, STORE, HALT.
  - Required: accWrite pulses in the EXECUTE cycles of instructions 1 and 2; reg1Write in instruction 3.
  - Final state: pc=3, halted=1, retiredCount=4, 3 cycles/instruction.
- Fetch wait states: instrValid delayed 2 cycles on each fetch.
  - instrReq stays high 3 cycles per fetch with instrAddr stable.
  - Each instruction takes 5 cycles.
- JZ both ways:
  - accumulatorZero=1 with JZ 0x40 -> pc=0x40.
  - accumulatorZero=0 -> pc=old+1.
  - JUMP 0x10 -> next instrAddr=0x10.
- Wrap: pc=0xFF executing NOP -> next fetch at 0x00.
  - retiredCount preset near 0xFFFF wraps to 0.
- Halt/restart: HALT at pc=7.
  - halted=1 and start pulses in DECODE are ignored.
  - start in HALTED -> FETCH at pc=8.
- Reset mid-fetch: isReset during FETCH wait -> instrReq=0 within the same cycle, pc=0, state IDLE; late instrValid is ignored.
